// File: rtl/cp0_irq_vec_if.sv
// Pipeline <-> CP0 interrupt unit bus: register access, interrupt handshake and force-jump.
interface cp0_irq_vec_if;
    logic [1:0]  oper;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        ir_en;
    logic [31:0] ret_addr;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        ir;
    logic        ir_valid;
    logic        ir_wait;
    logic [2:0]  ir_chan;

    modport master (
        output oper, addr_r, addr_w, data_w, ir_en, ret_addr,
        input  data_r, jump_en, jump_addr, ir, ir_valid, ir_wait, ir_chan
    );

    modport slave (
        input  oper, addr_r, addr_w, data_w, ir_en, ret_addr,
        output data_r, jump_en, jump_addr, ir, ir_valid, ir_wait, ir_chan
    );
endinterface

// File: rtl/cp0_irq_vec.sv
// Multi-line CP0 interrupt unit with fixed priority and per-channel vectoring.
// Define CP0_IR_EDGE_EN for sticky rising-edge pending bits; default is level mode.
module cp0_irq_vec #(
    parameter int          N_IR      = 4,
    parameter int          VEC_SHIFT = 4,
    parameter logic [31:0] EBASE_RST = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IR-1:0] ir_in,
    cp0_irq_vec_if.slave    bus
);
    localparam logic [1:0] OP_MTC0  = 2'd2;
    localparam logic [1:0] OP_ERET  = 2'd3;
    localparam logic [4:0] A_STATUS = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;
    localparam logic [4:0] A_EPC    = 5'd14;
    localparam logic [4:0] A_EBASE  = 5'd15;

    typedef enum logic [1:0] {IDLE, WAIT, HANDLER} state_t;

    state_t          state;
    logic [N_IR-1:0] ir_sync;
    logic [N_IR-1:0] ip;
    logic [N_IR-1:0] im;
    logic            ie;
    logic            exl;
    logic [2:0]      chan;
    logic [31:0]     epc;
    logic [31:0]     ebase;

    logic [N_IR-1:0] pend;
    logic            req;
    logic [2:0]      winner;
    logic            mtc0;
    logic            ie_clear;
    logic            take;
    logic            eret_go;
    logic            ir_int;

    assign pend     = ip & im;
    assign req      = ie & ~exl & (|pend);
    assign mtc0     = (bus.oper == OP_MTC0);
    assign ie_clear = mtc0 && (bus.addr_w == A_STATUS) && !bus.data_w[0];
    // A software write that disables interrupts beats a take in the same cycle.
    assign take     = (state == WAIT) && req && bus.ir_en && !ie_clear;
    assign eret_go  = (bus.oper == OP_ERET) && exl;
    assign ir_int   = (state == WAIT) && req;

    always_comb begin
        winner = '0;
        for (int i = 0; i < N_IR; i++)
            if (pend[i]) winner = 3'(i);
    end

    assign bus.ir       = ir_int;
    assign bus.ir_wait  = ir_int & ~bus.ir_en;
    assign bus.ir_valid = take;
    assign bus.ir_chan  = winner;
    assign bus.jump_en  = take | eret_go;

    always_comb begin
        bus.jump_addr = ebase;
        if (take)
            bus.jump_addr = ebase + (32'(winner) << VEC_SHIFT);
        else if (eret_go)
            bus.jump_addr = epc;
    end

    always_comb begin
        bus.data_r = '0;
        case (bus.addr_r)
            A_STATUS: begin
                bus.data_r[8 +: N_IR] = im;
                bus.data_r[1]         = exl;
                bus.data_r[0]         = ie;
            end
            A_CAUSE: begin
                bus.data_r[18:16]     = chan;
                bus.data_r[8 +: N_IR] = ip;
            end
            A_EPC:   bus.data_r = epc;
            A_EBASE: bus.data_r = ebase;
            default: bus.data_r = '0;
        endcase
    end

`ifdef CP0_IR_EDGE_EN
    logic [N_IR-1:0] ir_prev;
    logic [N_IR-1:0] ip_clr;

    // Pending bits clear when their channel is taken or software writes a 0.
    always_comb begin
        ip_clr = '0;
        for (int i = 0; i < N_IR; i++)
            if (take && winner == 3'(i)) ip_clr[i] = 1'b1;
        if (mtc0 && bus.addr_w == A_CAUSE)
            ip_clr = ip_clr | ~bus.data_w[8 +: N_IR];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ir_sync <= '0;
            ip      <= '0;
            im      <= '0;
            ie      <= 1'b0;
            exl     <= 1'b0;
            chan    <= '0;
            epc     <= '0;
            ebase   <= EBASE_RST;
`ifdef CP0_IR_EDGE_EN
            ir_prev <= '0;
`endif
        end else begin
            ir_sync <= ir_in;
`ifdef CP0_IR_EDGE_EN
            ir_prev <= ir_sync;
            ip      <= (ip & ~ip_clr) | (ir_sync & ~ir_prev);
`else
            ip      <= ir_sync;
`endif
            if (mtc0) begin
                case (bus.addr_w)
                    A_STATUS: begin
                        im  <= bus.data_w[8 +: N_IR];
                        exl <= bus.data_w[1];
                        ie  <= bus.data_w[0];
                    end
                    A_EPC:   epc   <= bus.data_w;
                    A_EBASE: ebase <= bus.data_w;
                    default: ;
                endcase
            end
            // Hardware updates on take/ERET override a same-cycle MTC0.
            if (take) begin
                epc  <= bus.ret_addr;
                exl  <= 1'b1;
                chan <= winner;
            end
            if (eret_go)
                exl <= 1'b0;

            case (state)
                IDLE:    if (req) state <= WAIT;
                WAIT: begin
                    if (take)
                        state <= HANDLER;
                    else if (!req || ie_clear)
                        state <= IDLE;
                end
                HANDLER: ;
                default: state <= IDLE;
            endcase
            if (eret_go)
                state <= IDLE;
        end
    end
endmodule
